// File: rtl/adder_arbiter_if.sv
// Request/response bus between NREQ adder clients and the shared-adder arbiter.
// Request lanes are packed; lane i occupies bits [32i+31:32i] of req_a/req_b.
interface adder_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic [NREQ-1:0]    req_sub;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_sum;
    logic               rsp_cout;
    logic               rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit ripple adder among NREQ add/sub clients.
// One grant per cycle; results come back through a single registered, id-tagged port.
module adder32Bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[32];
endmodule

module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    adder_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   rr_ptr;
    logic             can_issue;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  req_ready;
    logic             accept;
    logic [IDW-1:0]   ptr_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_sub;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_cout;
    logic             adder_ovf;

    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic             rsp_ovf_q;

    // A new op may issue only if the output register is empty or drains this cycle.
    assign can_issue = !rsp_valid_q || bus.rsp_ready;

    // Walk downward in priority so the lane closest to rr_ptr is written last and wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req_valid[idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && can_issue && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = req_ready;
    assign accept        = |(bus.req_valid & req_ready);
    assign ptr_next      = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    assign op_a   = bus.req_a[int'(grant_idx) * WIDTH +: WIDTH];
    assign op_b   = bus.req_b[int'(grant_idx) * WIDTH +: WIDTH];
    assign op_cin = bus.req_cin[grant_idx];
    assign op_sub = bus.req_sub[grant_idx];

    // Subtract is A + ~B + 1; the client's carry-in only matters for add.
    assign adder_b   = op_sub ? ~op_b : op_b;
    assign adder_cin = op_sub ? 1'b1 : op_cin;

    adder32Bit u_adder (
        .a    (op_a),
        .b    (adder_b),
        .cin  (adder_cin),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    assign adder_ovf = (op_a[WIDTH-1] == adder_b[WIDTH-1]) &&
                       (adder_sum[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rr_ptr      <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant_idx;
            rsp_sum_q   <= adder_sum;
            rsp_cout_q  <= adder_cout;
            rsp_ovf_q   <= adder_ovf;
            rr_ptr      <= ptr_next;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
endmodule
